// File: rtl/ieee754_to_fixed.sv
// IEEE-754 (single/double) to sign/integer/fraction fixed-point converter.
// Two register stages (classify, shift+flag) with valid/ready flow control.
module ieee754_to_fixed #(
  parameter  int PRECISION  = 32,
  localparam int DATA_WIDTH = 32
) (
  input  logic                  I_Clk,
  input  logic                  I_Reset,
  input  logic                  I_Valid,
  output logic                  O_Ready,
  input  logic [PRECISION-1:0]  I_Op,
  output logic                  O_Valid,
  input  logic                  I_Ready,
  output logic                  O_Sign,
  output logic [DATA_WIDTH-1:0] O_Int,
  output logic [DATA_WIDTH-1:0] O_Fract,
  output logic                  O_Overflow,
  output logic                  O_Invalid,
  output logic                  O_Inexact
);

  localparam int EXP_W  = (PRECISION == 64) ? 11 : 8;
  localparam int MANT_W = (PRECISION == 64) ? 52 : 23;
  localparam int BIAS   = (PRECISION == 64) ? 1023 : 127;
  localparam int OP_W   = 1 + EXP_W + MANT_W;
  localparam int EW     = EXP_W + 2;
  localparam int WW     = 2 * DATA_WIDTH + MANT_W;
  localparam int SH_W   = $clog2(2 * DATA_WIDTH);

  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
  localparam logic signed [EW-1:0] DW_S   = EW'(DATA_WIDTH);

  typedef enum logic [2:0] {C_ZERO, C_DENORM, C_NORM, C_INF, C_NAN} cls_t;

  logic [OP_W-1:0]   op;
  logic              op_sign;
  logic [EXP_W-1:0]  op_exp;
  logic [MANT_W-1:0] op_mant;
  cls_t              op_cls;
  logic signed [EW-1:0] op_e;

  logic                 s1_valid;
  logic                 s1_sign;
  logic signed [EW-1:0] s1_e;
  logic [MANT_W:0]      s1_m;
  cls_t                 s1_cls;

  logic                  s2_valid;
  logic                  advance;
  logic [SH_W-1:0]       sh;
  logic [WW-1:0]         wide;
  logic                  n_sign, n_ovf, n_inv, n_inx;
  logic [DATA_WIDTH-1:0] n_int, n_fract;

  // Pipe moves only when the output slot is empty or being drained.
  assign advance = !s2_valid || I_Ready;
  assign O_Ready = advance;
  assign O_Valid = s2_valid;

  assign op      = OP_W'(I_Op);
  assign op_sign = op[OP_W-1];
  assign op_exp  = op[OP_W-2 -: EXP_W];
  assign op_mant = op[MANT_W-1:0];
  assign op_e    = $signed({2'b00, op_exp}) - BIAS_S;

  always_comb begin
    op_cls = C_NORM;
    if (op_exp == '0)
      op_cls = (op_mant == '0) ? C_ZERO : C_DENORM;
    else if (&op_exp)
      op_cls = (op_mant == '0) ? C_INF : C_NAN;
  end

  // The window's bit 0 weighs 2^-(DATA_WIDTH+MANT_W), so M lands at E+DATA_WIDTH;
  // the low MANT_W bits are exactly what truncation discards.
  assign sh   = SH_W'(s1_e + DW_S);
  assign wide = WW'(s1_m) << sh;

  always_comb begin
    n_sign  = s1_sign;
    n_int   = '0;
    n_fract = '0;
    n_ovf   = 1'b0;
    n_inv   = 1'b0;
    n_inx   = 1'b0;
    case (s1_cls)
      C_ZERO: ;
      C_DENORM: n_inx = 1'b1;
      C_INF: begin
        n_int   = '1;
        n_fract = '1;
        n_ovf   = 1'b1;
      end
      C_NAN: begin
        n_sign = 1'b0;
        n_inv  = 1'b1;
      end
      default: begin
        if (s1_e >= DW_S) begin
          n_int   = '1;
          n_fract = '1;
          n_ovf   = 1'b1;
        end else if (s1_e < -DW_S) begin
          n_inx = 1'b1;
        end else begin
          {n_int, n_fract} = wide[WW-1:MANT_W];
          n_inx            = |wide[MANT_W-1:0];
        end
      end
    endcase
    if (!s1_valid) begin
      n_sign = 1'b0;
      n_int  = '0;
      n_fract = '0;
      n_ovf  = 1'b0;
      n_inv  = 1'b0;
      n_inx  = 1'b0;
    end
  end

  always_ff @(posedge I_Clk) begin
    if (I_Reset) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_e       <= '0;
      s1_m       <= '0;
      s1_cls     <= C_ZERO;
      s2_valid   <= 1'b0;
      O_Sign     <= 1'b0;
      O_Int      <= '0;
      O_Fract    <= '0;
      O_Overflow <= 1'b0;
      O_Invalid  <= 1'b0;
      O_Inexact  <= 1'b0;
    end else if (advance) begin
      s1_valid <= I_Valid;
      if (I_Valid) begin
        s1_sign <= op_sign;
        s1_e    <= op_e;
        s1_m    <= {1'b1, op_mant};
        s1_cls  <= op_cls;
      end
      s2_valid   <= s1_valid;
      O_Sign     <= n_sign;
      O_Int      <= n_int;
      O_Fract    <= n_fract;
      O_Overflow <= n_ovf;
      O_Invalid  <= n_inv;
      O_Inexact  <= n_inx;
    end
  end

endmodule
